// File: rtl/spmv_row_sched.sv
// CSR row scheduler: turns a row-pointer stream into per-row nnz counts for the dot
// engine and re-pairs the returned row sums with their row indices, in row order.
module spmv_row_sched #(
   parameter int DEPTH = 16,
   parameter int ROW_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [ROW_W-1:0] num_rows,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [31:0]      S_AXIS_PTR_tdata,
   input  logic             S_AXIS_PTR_tvalid,
   output logic             S_AXIS_PTR_tready,
   output logic [31:0]      M_AXIS_TIMES_tdata,
   output logic             M_AXIS_TIMES_tvalid,
   input  logic             M_AXIS_TIMES_tready,
   input  logic [63:0]      S_AXIS_DOT_tdata,
   input  logic             S_AXIS_DOT_tvalid,
   output logic             S_AXIS_DOT_tready,
   output logic [63:0]      M_AXIS_Y_tdata,
   output logic [ROW_W-1:0] M_AXIS_Y_tuser,
   output logic             M_AXIS_Y_tlast,
   output logic             M_AXIS_Y_tvalid,
   input  logic             M_AXIS_Y_tready
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_FIRST, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] num_rows_q, num_rows_d;
   logic [ROW_W-1:0] row_idx_q, row_idx_d;
   logic [31:0]      prev_ptr_q, prev_ptr_d;
   logic             err_q, err_d;
   logic [31:0]      times_data_q, times_data_d;
   logic             times_vld_q, times_vld_d;
   logic [ROW_W:0]   tag_mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;

   logic             fifo_empty, fifo_full, ptr_rdy, ptr_acc, push, pop;
   logic [ROW_W:0]   push_tag, head_tag;
   logic [31:0]      nnz;

   // Tag layout is {row index, empty-row flag}; pointers carry an extra wrap bit.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_tag   = tag_mem_q[rd_ptr_q[AW-1:0]];

   // A free TIMES slot is required even for empty rows, keeping the handshake simple.
   assign ptr_rdy = (state_q == S_FIRST) ||
                    ((state_q == S_RUN) && !fifo_full &&
                     (!times_vld_q || M_AXIS_TIMES_tready));
   assign ptr_acc = ptr_rdy && S_AXIS_PTR_tvalid;
   assign S_AXIS_PTR_tready = ptr_rdy;

   assign err                 = err_q;
   assign M_AXIS_TIMES_tdata  = times_data_q;
   assign M_AXIS_TIMES_tvalid = times_vld_q;

   always_comb begin
      state_d      = state_q;
      num_rows_d   = num_rows_q;
      row_idx_d    = row_idx_q;
      prev_ptr_d   = prev_ptr_q;
      err_d        = err_q;
      times_data_d = times_data_q;
      times_vld_d  = times_vld_q;
      push         = 1'b0;
      push_tag     = '0;
      nnz          = '0;
      busy         = 1'b0;
      done         = 1'b0;
      if (times_vld_q && M_AXIS_TIMES_tready) times_vld_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_rows_d = num_rows;
               err_d      = 1'b0;
               state_d    = S_FIRST;
            end
         end
         S_FIRST: begin
            busy = 1'b1;
            if (ptr_acc) begin
               prev_ptr_d = S_AXIS_PTR_tdata;
               row_idx_d  = '0;
               state_d    = (num_rows_q == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (ptr_acc) begin
               // A decreasing pointer flags err and degrades the row to empty.
               if (S_AXIS_PTR_tdata < prev_ptr_q) err_d = 1'b1;
               else nnz = S_AXIS_PTR_tdata - prev_ptr_q;
               prev_ptr_d = S_AXIS_PTR_tdata;
               push       = 1'b1;
               push_tag   = {row_idx_q, (nnz == 32'd0)};
               if (nnz != 32'd0) begin
                  times_data_d = nnz;
                  times_vld_d  = 1'b1;
               end
               row_idx_d = row_idx_q + ROW_W'(1);
               if (row_idx_q == num_rows_q - ROW_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (fifo_empty) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Empty rows bypass the dot engine; otherwise Y mirrors the DOT stream.
   always_comb begin
      M_AXIS_Y_tvalid   = 1'b0;
      M_AXIS_Y_tdata    = '0;
      M_AXIS_Y_tuser    = '0;
      M_AXIS_Y_tlast    = 1'b0;
      S_AXIS_DOT_tready = 1'b0;
      if (!fifo_empty) begin
         M_AXIS_Y_tuser = head_tag[ROW_W:1];
         M_AXIS_Y_tlast = (head_tag[ROW_W:1] == num_rows_q - ROW_W'(1));
         if (head_tag[0]) begin
            M_AXIS_Y_tvalid = 1'b1;
         end else begin
            M_AXIS_Y_tvalid   = S_AXIS_DOT_tvalid;
            M_AXIS_Y_tdata    = S_AXIS_DOT_tdata;
            S_AXIS_DOT_tready = M_AXIS_Y_tready;
         end
      end
   end

   assign pop = M_AXIS_Y_tvalid && M_AXIS_Y_tready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         num_rows_q   <= '0;
         row_idx_q    <= '0;
         prev_ptr_q   <= '0;
         err_q        <= 1'b0;
         times_data_q <= '0;
         times_vld_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         num_rows_q   <= num_rows_d;
         row_idx_q    <= row_idx_d;
         prev_ptr_q   <= prev_ptr_d;
         err_q        <= err_d;
         times_data_q <= times_data_d;
         times_vld_q  <= times_vld_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q[AW-1:0]] <= push_tag;
   end

endmodule

// File: tb/tb_spmv_row_sched.sv
// Bench for spmv_row_sched: table of directed jobs, a mid-job reset sequence and
// random jobs, all scored against a per-row model built from the pointer list.
module tb_spmv_row_sched;
   localparam int DEPTH = 4;
   localparam int ROW_W = 32;

   logic             clk = 1'b0;
   logic             rstn, start;
   logic [ROW_W-1:0] num_rows;
   logic             busy, done, err;
   logic [31:0]      S_AXIS_PTR_tdata;
   logic             S_AXIS_PTR_tvalid, S_AXIS_PTR_tready;
   logic [31:0]      M_AXIS_TIMES_tdata;
   logic             M_AXIS_TIMES_tvalid, M_AXIS_TIMES_tready;
   logic [63:0]      S_AXIS_DOT_tdata;
   logic             S_AXIS_DOT_tvalid, S_AXIS_DOT_tready;
   logic [63:0]      M_AXIS_Y_tdata;
   logic [ROW_W-1:0] M_AXIS_Y_tuser;
   logic             M_AXIS_Y_tlast, M_AXIS_Y_tvalid, M_AXIS_Y_tready;

   always #5 clk = ~clk;

   spmv_row_sched #(.DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
      .busy(busy), .done(done), .err(err),
      .S_AXIS_PTR_tdata(S_AXIS_PTR_tdata), .S_AXIS_PTR_tvalid(S_AXIS_PTR_tvalid),
      .S_AXIS_PTR_tready(S_AXIS_PTR_tready),
      .M_AXIS_TIMES_tdata(M_AXIS_TIMES_tdata), .M_AXIS_TIMES_tvalid(M_AXIS_TIMES_tvalid),
      .M_AXIS_TIMES_tready(M_AXIS_TIMES_tready),
      .S_AXIS_DOT_tdata(S_AXIS_DOT_tdata), .S_AXIS_DOT_tvalid(S_AXIS_DOT_tvalid),
      .S_AXIS_DOT_tready(S_AXIS_DOT_tready),
      .M_AXIS_Y_tdata(M_AXIS_Y_tdata), .M_AXIS_Y_tuser(M_AXIS_Y_tuser),
      .M_AXIS_Y_tlast(M_AXIS_Y_tlast), .M_AXIS_Y_tvalid(M_AXIS_Y_tvalid),
      .M_AXIS_Y_tready(M_AXIS_Y_tready)
   );

   // rnd: random valids/readies; ymode 0=always,1=one-in-three,2=random;
   // eacc: PTR words expected accepted by the end of the Y stall (-1 = unchecked)
   typedef struct {
      int          n;
      int unsigned ptr[8];
      int          rnd;
      int          ymode;
      int          thold;
      int          yhold;
      int          eacc;
      int          ent;
      bit          eerr;
   } vec_t;
   vec_t tbl[6];

   int n_vec = 0;
   int n_bad = 0;

   int unsigned jp[32];
   int          jn, j_rnd, j_ymode, j_thold, j_yhold, j_eacc;
   logic [31:0] exp_times[$];
   logic [63:0] exp_yd[$];
   logic [63:0] dotv[$];
   bit          exp_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      S_AXIS_PTR_tvalid = 1'b0;
      S_AXIS_PTR_tdata = '0;
      M_AXIS_TIMES_tready = 1'b0;
      S_AXIS_DOT_tvalid = 1'b0;
      S_AXIS_DOT_tdata = '0;
      M_AXIS_Y_tready = 1'b0;
   endtask

   // Per row: nnz = next - this pointer; zero or decreasing rows yield 0.0.
   task automatic build_model();
      logic [63:0] v;
      exp_times.delete();
      exp_yd.delete();
      dotv.delete();
      exp_err = 1'b0;
      for (int i = 0; i < jn; i++) begin
         if (jp[i+1] < jp[i]) begin
            exp_err = 1'b1;
            exp_yd.push_back(64'h0);
         end else if (jp[i+1] == jp[i]) begin
            exp_yd.push_back(64'h0);
         end else begin
            exp_times.push_back(jp[i+1] - jp[i]);
            v = {$urandom, $urandom} | 64'h1;
            dotv.push_back(v);
            exp_yd.push_back(v);
         end
      end
   endtask

   task automatic run_job(output int ntimes);
      int pj, ti, yi, dones, cyc, acc_cyc, done_cyc;
      bit pvld, dvld, tr, yr, ptr_hs, t_hs, y_hs, d_hs, prev_tv, prev_tr;
      logic [31:0] prev_td;
      logic [63:0] dq[$];
      pj = 0; ti = 0; yi = 0; dones = 0; acc_cyc = 0; done_cyc = 0;
      pvld = 0; dvld = 0; prev_tv = 0; prev_tr = 0; prev_td = '0;
      build_model();
      start = 1'b1;
      num_rows = jn;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("err_after_start", err, 0);
      for (cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
         if (!pvld && pj <= jn && (j_rnd == 0 || $urandom_range(3) != 0)) pvld = 1;
         tr = (cyc >= j_thold) && (j_rnd == 0 || $urandom_range(3) != 0);
         case (j_ymode)
            0:       yr = 1;
            1:       yr = (cyc % 3 == 0);
            default: yr = ($urandom_range(1) == 1);
         endcase
         if (cyc < j_yhold) yr = 0;
         if (!dvld && dq.size() > 0 && (j_rnd == 0 || $urandom_range(1) == 1)) dvld = 1;
         S_AXIS_PTR_tvalid   = pvld;
         S_AXIS_PTR_tdata    = pvld ? jp[pj] : 32'h0;
         M_AXIS_TIMES_tready = tr;
         M_AXIS_Y_tready     = yr;
         S_AXIS_DOT_tvalid   = dvld;
         S_AXIS_DOT_tdata    = dvld ? dq[0] : 64'hBAD0_DEAD_BAD0_DEAD;
         #1;
         if (prev_tv && !prev_tr) begin
            chk("times_valid_held", M_AXIS_TIMES_tvalid, 1);
            chk("times_data_held", M_AXIS_TIMES_tdata, prev_td);
         end
         if (M_AXIS_TIMES_tvalid && !tr) chk("ptr_ready_times_stalled", S_AXIS_PTR_tready, 0);
         if (j_eacc >= 0 && cyc == j_yhold - 1) chk("ptr_accepted_y_stalled", pj, j_eacc);
         ptr_hs = pvld && S_AXIS_PTR_tready;
         t_hs   = M_AXIS_TIMES_tvalid && tr;
         y_hs   = M_AXIS_Y_tvalid && yr;
         d_hs   = dvld && S_AXIS_DOT_tready;
         if (t_hs) begin
            if (ti < exp_times.size()) begin
               chk("times_data", M_AXIS_TIMES_tdata, exp_times[ti]);
               dq.push_back(dotv[ti]);
            end else begin
               chk("times_count", ti + 1, exp_times.size());
            end
            ti++;
         end
         if (y_hs) begin
            if (yi < jn) begin
               chk("y_data", M_AXIS_Y_tdata, exp_yd[yi]);
               chk("y_row", M_AXIS_Y_tuser, yi);
               chk("y_last", M_AXIS_Y_tlast, (yi == jn - 1));
            end else begin
               chk("y_count", yi + 1, jn);
            end
            yi++;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
         end
         prev_tv = M_AXIS_TIMES_tvalid;
         prev_td = M_AXIS_TIMES_tdata;
         prev_tr = tr;
         @(negedge clk);
         if (ptr_hs) begin
            if (pj == 0) acc_cyc = cyc;
            pj++;
            pvld = 0;
         end
         if (d_hs) begin
            void'(dq.pop_front());
            dvld = 0;
         end
      end
      chk("job_done_seen", dones, 1);
      chk("times_total", ti, exp_times.size());
      chk("y_total", yi, jn);
      chk("ptr_total", pj, jn + 1);
      chk("err_final", err, exp_err);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      if (jn == 0 && dones == 1) chk("zero_rows_done_latency", done_cyc - acc_cyc, 2);
      idle_inputs();
      ntimes = ti;
   endtask

   task automatic load_vec(input int i);
      jn = tbl[i].n;
      for (int k = 0; k < 8; k++) jp[k] = tbl[i].ptr[k];
      j_rnd = tbl[i].rnd; j_ymode = tbl[i].ymode; j_thold = tbl[i].thold;
      j_yhold = tbl[i].yhold; j_eacc = tbl[i].eacc;
   endtask

   initial begin
      int nt;
      tbl[0] = '{3, '{0, 3, 3, 5, 0, 0, 0, 0}, 0, 0, 0, 0, -1, 2, 1'b0};
      tbl[1] = '{3, '{0, 3, 3, 5, 0, 0, 0, 0}, 0, 1, 5, 0, -1, 2, 1'b0};
      tbl[2] = '{0, '{7, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 0, -1, 0, 1'b0};
      tbl[3] = '{6, '{9, 9, 9, 9, 9, 9, 9, 0}, 0, 0, 0, 12, 5, 0, 1'b0};
      tbl[4] = '{2, '{0, 4, 2, 0, 0, 0, 0, 0}, 0, 0, 0, 0, -1, 1, 1'b1};
      tbl[5] = '{4, '{10, 11, 15, 15, 16, 0, 0, 0}, 1, 2, 2, 0, -1, 3, 1'b0};

      rstn = 1'b0;
      num_rows = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ptr_ready", S_AXIS_PTR_tready, 0);
      chk("rst_times_valid", M_AXIS_TIMES_tvalid, 0);
      chk("rst_times_data", M_AXIS_TIMES_tdata, 0);
      chk("rst_dot_ready", S_AXIS_DOT_tready, 0);
      chk("rst_y_valid", M_AXIS_Y_tvalid, 0);
      chk("rst_y_data", M_AXIS_Y_tdata, 0);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         load_vec(i);
         run_job(nt);
         chk("tbl_times_count", nt, tbl[i].ent);
         chk("tbl_err", err, tbl[i].eerr);
         @(negedge clk);
      end

      // Mid-job reset with rows in flight, then a clean job.
      start = 1'b1;
      num_rows = 6;
      @(negedge clk);
      start = 1'b0;
      M_AXIS_TIMES_tready = 1'b1;
      S_AXIS_PTR_tvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         S_AXIS_PTR_tdata = 2 * k;
         @(negedge clk);
      end
      chk("midjob_busy", busy, 1);
      rstn = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_times_valid", M_AXIS_TIMES_tvalid, 0);
      chk("midrst_y_valid", M_AXIS_Y_tvalid, 0);
      chk("midrst_ptr_ready", S_AXIS_PTR_tready, 0);
      rstn = 1'b1;
      S_AXIS_DOT_tvalid = 1'b1;
      S_AXIS_DOT_tdata = 64'h3FF8_0000_0000_0000;
      M_AXIS_Y_tready = 1'b1;
      #1;
      chk("untagged_dot_y_valid", M_AXIS_Y_tvalid, 0);
      chk("untagged_dot_ready", S_AXIS_DOT_tready, 0);
      @(negedge clk);
      idle_inputs();
      load_vec(0);
      run_job(nt);
      chk("post_reset_times_count", nt, 2);
      @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         jn = $urandom_range(24, 0);
         jp[0] = $urandom_range(100);
         for (int k = 1; k <= jn; k++) begin
            if ($urandom_range(9) == 0 && jp[k-1] >= 3) jp[k] = jp[k-1] - 3;
            else jp[k] = jp[k-1] + $urandom_range(3);
         end
         j_rnd = 1; j_ymode = 2; j_thold = $urandom_range(3);
         j_yhold = $urandom_range(8); j_eacc = -1;
         run_job(nt);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
